// File: rtl/bin_to_gray.sv
// Combinational binary-to-reflected-Gray conversion, parametrised by width.
// Adjacent binary values, including the all-ones/zero wrap, differ in exactly one Gray bit.
module bin_to_gray #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter with registered binary and Gray outputs, optional saturation,
// and one-cycle wrap/saturation event pulses. Priority: reset, load, count, hold.
module gray_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] binary_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             sat_o
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Power-up values match the reset state.
  logic [WIDTH-1:0] binary_q = '0;
  logic [WIDTH-1:0] gray_q   = '0;
  logic             wrap_q   = 1'b0;
  logic             sat_q    = 1'b0;

  logic [WIDTH-1:0] binary_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;
  logic             sat_d;

  assign tc_o = dir_i ? (binary_q == ALL_ONES) : (binary_q == '0);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    binary_d = binary_q;
    wrap_d   = 1'b0;
    sat_d    = 1'b0;
    if (load_i) begin
      binary_d = load_value_i;
    end else if (ce_i) begin
      if ((SATURATE != 0) && tc_o) begin
        sat_d = 1'b1;
      end else begin
        binary_d = dir_i ? (binary_q + ONE) : (binary_q - ONE);
        wrap_d   = (SATURATE == 0) && tc_o;
      end
    end
  end

  // Gray register is fed from the next-state binary, so both outputs update together.
  bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
    .bin_i  (binary_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst_i) begin
      binary_q <= '0;
      gray_q   <= '0;
      wrap_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      binary_q <= binary_d;
      gray_q   <= gray_d;
      wrap_q   <= wrap_d;
      sat_q    <= sat_d;
    end
  end

  assign binary_o = binary_q;
  assign gray_o   = gray_q;
  assign wrap_o   = wrap_q;
  assign sat_o    = sat_q;

`ifdef FORMAL
  logic past_valid_q = 1'b0;
  always_ff @(posedge clk_i) past_valid_q <= 1'b1;

  logic step_ok;
  logic step_blocked;
  assign step_ok      = !rst_i && !load_i && ce_i && ((SATURATE == 0) || !tc_o);
  assign step_blocked = !rst_i && !load_i && ce_i && (SATURATE != 0) && tc_o;

  a_reset: assert property (@(posedge clk_i)
    rst_i |=> (binary_o == '0) && (gray_o == '0) && !wrap_o && !sat_o);
  a_load: assert property (@(posedge clk_i)
    (!rst_i && load_i) |=> (binary_o == $past(load_value_i)) && !wrap_o && !sat_o);
  a_up: assert property (@(posedge clk_i)
    (step_ok && dir_i) |=> binary_o == $past(binary_o) + ONE);
  a_down: assert property (@(posedge clk_i)
    (step_ok && !dir_i) |=> binary_o == $past(binary_o) - ONE);
  a_hold: assert property (@(posedge clk_i)
    (!rst_i && !load_i && !ce_i) |=> $stable(binary_o) && $stable(gray_o) && !wrap_o && !sat_o);
  a_gray: assert property (@(posedge clk_i) gray_o == (binary_o ^ (binary_o >> 1)));
  a_one_bit: assert property (@(posedge clk_i)
    step_ok |=> $onehot(gray_o ^ $past(gray_o)));
  a_wrap: assert property (@(posedge clk_i) disable iff (!past_valid_q)
    wrap_o == $past(step_ok && tc_o && (SATURATE == 0)));
  a_sat: assert property (@(posedge clk_i) disable iff (!past_valid_q)
    sat_o == $past(step_blocked));
  a_sat_hold: assert property (@(posedge clk_i) step_blocked |=> $stable(binary_o));
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed and randomised checks of gray_updown_counter at WIDTH=4, one instance in
// wrap mode (a_*) and one in saturate mode (b_*), both driven by the same inputs.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [3:0] a_bin, a_gray, b_bin, b_gray;
  logic       a_tc, a_wrap, a_sat, b_tc, b_wrap, b_sat;

  int total = 0;
  int bad = 0;

  // Hand-computed 4-bit reflected Gray codes for 0..15.
  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(4), .SATURATE(0)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .dir_i(dir), .load_i(load),
    .load_value_i(lv), .binary_o(a_bin), .gray_o(a_gray), .tc_o(a_tc),
    .wrap_o(a_wrap), .sat_o(a_sat)
  );

  gray_updown_counter #(.WIDTH(4), .SATURATE(1)) dut_sat (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .dir_i(dir), .load_i(load),
    .load_value_i(lv), .binary_o(b_bin), .gray_o(b_gray), .tc_o(b_tc),
    .wrap_o(b_wrap), .sat_o(b_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic l, input logic [3:0] v,
                       input logic c, input logic d);
    rst = r; load = l; lv = v; ce = c; dir = d;
    #1;
  endtask

  task automatic test_reset();
    total++;
    if ({a_bin, a_gray, a_wrap, a_sat} !== 10'd0 || {b_bin, b_gray, b_wrap, b_sat} !== 10'd0) begin
      bad++;
      $display("FAIL power_up: a=%h/%h/%b/%b b=%h/%h/%b/%b need all 0",
               a_bin, a_gray, a_wrap, a_sat, b_bin, b_gray, b_wrap, b_sat);
    end
    drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'd9, 1'b1, 1'b1);
    tick();
    total++;
    if ({a_bin, a_gray, a_wrap, a_sat} !== 10'd0 || {b_bin, b_gray, b_wrap, b_sat} !== 10'd0) begin
      bad++;
      $display("FAIL reset_over_load: a=%h/%h/%b/%b b=%h/%h/%b/%b need all 0",
               a_bin, a_gray, a_wrap, a_sat, b_bin, b_gray, b_wrap, b_sat);
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] prev_gray;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      prev_gray = a_gray;
      total++;
      if (a_tc !== (i == 16)) begin
        bad++;
        $display("FAIL up_tc step %0d: got %b need %b", i, a_tc, (i == 16));
      end
      tick();
      exp_a = 4'(i);
      exp_b = (i >= 15) ? 4'd15 : 4'(i);
      total++;
      if (a_bin !== exp_a || a_gray !== gray_tab[exp_a] || a_wrap !== (i == 16) || a_sat !== 1'b0) begin
        bad++;
        $display("FAIL up_wrap step %0d: got %h/%h/%b/%b need %h/%h/%b/0",
                 i, a_bin, a_gray, a_wrap, a_sat, exp_a, gray_tab[exp_a], (i == 16));
      end
      total++;
      if ($countones(a_gray ^ prev_gray) != 1) begin
        bad++;
        $display("FAIL up_one_bit step %0d: gray %h -> %h", i, prev_gray, a_gray);
      end
      total++;
      if (b_bin !== exp_b || b_gray !== gray_tab[exp_b] || b_sat !== (i == 16) || b_wrap !== 1'b0) begin
        bad++;
        $display("FAIL up_sat step %0d: got %h/%h/%b/%b need %h/%h/0/%b",
                 i, b_bin, b_gray, b_wrap, b_sat, exp_b, gray_tab[exp_b], (i == 16));
      end
    end
  endtask

  task automatic test_down_wrap();
    drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    total++;
    if (a_bin !== 4'd0 || a_tc !== 1'b1 || b_tc !== 1'b1) begin
      bad++;
      $display("FAIL down_load0: bin=%h tc=%b/%b need 0 1/1", a_bin, a_tc, b_tc);
    end
    tick();
    total++;
    if (a_bin !== 4'd15 || a_gray !== 4'd8 || a_wrap !== 1'b1 || a_sat !== 1'b0) begin
      bad++;
      $display("FAIL down_wrap: got %h/%h/%b/%b need f/8/1/0", a_bin, a_gray, a_wrap, a_sat);
    end
    total++;
    if (b_bin !== 4'd0 || b_gray !== 4'd0 || b_sat !== 1'b1 || b_wrap !== 1'b0) begin
      bad++;
      $display("FAIL down_sat: got %h/%h/%b/%b need 0/0/0/1", b_bin, b_gray, b_wrap, b_sat);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    total++;
    if (a_bin !== 4'd15 || a_gray !== 4'd8 || a_wrap !== 1'b0 || b_sat !== 1'b0 || b_bin !== 4'd0) begin
      bad++;
      $display("FAIL hold: got a=%h/%h wrap=%b b=%h sat=%b need f/8 0 0 0",
               a_bin, a_gray, a_wrap, b_bin, b_sat);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_a [3] = '{4'd15, 4'd0, 4'd1};
    logic       exp_s [3] = '{1'b0, 1'b1, 1'b1};
    drive(1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (b_bin !== 4'd15 || b_gray !== 4'd8 || b_sat !== exp_s[i] || b_wrap !== 1'b0) begin
        bad++;
        $display("FAIL sat_step %0d: got %h/%h wrap=%b sat=%b need f/8 0 %b",
                 i + 1, b_bin, b_gray, b_wrap, b_sat, exp_s[i]);
      end
      total++;
      if (a_bin !== exp_a[i] || a_wrap !== (i == 1) || a_sat !== 1'b0) begin
        bad++;
        $display("FAIL sat_ref_wrap %0d: got %h wrap=%b sat=%b need %h %b 0",
                 i + 1, a_bin, a_wrap, a_sat, exp_a[i], (i == 1));
      end
    end
  endtask

  task automatic test_load_priority();
    drive(1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
    tick();
    total++;
    if (a_bin !== 4'd9 || a_gray !== 4'd13 || a_wrap !== 1'b0 ||
        b_bin !== 4'd9 || b_gray !== 4'd13 || b_sat !== 1'b0) begin
      bad++;
      $display("FAIL load_over_ce: got a=%h/%h b=%h/%h need 9/d 9/d", a_bin, a_gray, b_bin, b_gray);
    end
    drive(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 4'd15, 1'b1, 1'b1);
    tick();
    total++;
    if (a_bin !== 4'd15 || a_wrap !== 1'b0 || b_bin !== 4'd15 || b_sat !== 1'b0) begin
      bad++;
      $display("FAIL load_at_tc: got a=%h wrap=%b b=%h sat=%b need f 0 f 0", a_bin, a_wrap, b_bin, b_sat);
    end
  endtask

  task automatic test_dir_reversal();
    logic       dirs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp  [4] = '{4'd14, 4'd15, 4'd14, 4'd13};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, dirs[i]);
      tick();
      total++;
      if (a_bin !== exp[i] || a_gray !== gray_tab[exp[i]]) begin
        bad++;
        $display("FAIL dir_reversal %0d: got %h/%h need %h/%h", i, a_bin, a_gray, exp[i], gray_tab[exp[i]]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    total++;
    if (a_bin !== 4'd0 || a_gray !== 4'd0 || b_bin !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_count: got a=%h/%h b=%h need 0/0 0", a_bin, a_gray, b_bin);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    total++;
    if (a_bin !== 4'd1 || a_gray !== 4'd1 || b_bin !== 4'd1) begin
      bad++;
      $display("FAIL resume_after_reset: got a=%h/%h b=%h need 1/1 1", a_bin, a_gray, b_bin);
    end
  endtask

  task automatic test_random();
    logic [3:0] ma, mb, pa, pb;
    logic       wa, sb, r, l, c, d;
    logic [3:0] v;
    ma = a_bin;
    mb = b_bin;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(63) == 0);
      l = ($urandom_range(15) == 0);
      c = $urandom_range(1);
      d = $urandom_range(1);
      v = 4'($urandom_range(15));
      drive(r, l, v, c, d);
      pa = a_gray;
      pb = b_gray;
      wa = 1'b0;
      sb = 1'b0;
      if (r) begin
        ma = 4'd0;
        mb = 4'd0;
      end else if (l) begin
        ma = v;
        mb = v;
      end else if (c) begin
        if (d) begin
          wa = (ma == 4'd15);
          ma = ma + 4'd1;
          if (mb == 4'd15) sb = 1'b1; else mb = mb + 4'd1;
        end else begin
          wa = (ma == 4'd0);
          ma = ma - 4'd1;
          if (mb == 4'd0) sb = 1'b1; else mb = mb - 4'd1;
        end
      end
      tick();
      total++;
      if (a_bin !== ma || a_gray !== gray_tab[ma] || a_wrap !== wa || a_sat !== 1'b0) begin
        bad++;
        $display("FAIL rand_wrap cyc %0d: got %h/%h/%b/%b need %h/%h/%b/0",
                 n, a_bin, a_gray, a_wrap, a_sat, ma, gray_tab[ma], wa);
      end
      total++;
      if (b_bin !== mb || b_gray !== gray_tab[mb] || b_sat !== sb || b_wrap !== 1'b0) begin
        bad++;
        $display("FAIL rand_sat cyc %0d: got %h/%h/%b/%b need %h/%h/0/%b",
                 n, b_bin, b_gray, b_wrap, b_sat, mb, gray_tab[mb], sb);
      end
      if (!r && !l && c) begin
        total++;
        if ($countones(a_gray ^ pa) != 1 || (!sb && $countones(b_gray ^ pb) != 1)) begin
          bad++;
          $display("FAIL rand_one_bit cyc %0d: a %h->%h b %h->%h", n, pa, a_gray, pb, b_gray);
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load_priority();
    test_dir_reversal();
    test_reset_mid_count();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
